mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage data-memory initiator of the dual-issue MIPS core; consumes the registered memory request from the EX/MEM pipeline register (M_mem_* fields) and drives an SRAM-like data-cache interface (req/addr_ok/data_ok).
- Generates size/byte strobes and replicated store data, detects misaligned accesses, and extracts/sign-extends load data.
- Produces mem_stall, which the hazard unit uses to hold the EX/MEM and earlier stages until the access completes.

Parameters:
- ADDR_W, 32, physical address width on the data bus.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- M_mem_en  in  1  request valid from EX/MEM register.
- M_mem_ren  in  1  load request.
- M_mem_wen  in  1  store request.
- M_mem_op  in  6  MIPS opcode: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B.
- M_mem_addr  in  32  virtual address, used for alignment checks and bad-vaddr.
- M_mem_wdata  in  32  store data (rt value, unaligned).
- M_mem_pa  in  ADDR_W  translated physical address.
- M_mem_uncached  in  1  uncached attribute.
- flush  in  1  MEM-stage exception/eret flush; blocks new requests.
- advance  in  1  MEM/WB register enable this cycle (pipeline consumes MEM result).
- data_req  out  1  bus request.
- data_wr  out  1  1 = store.
- data_size  out  2  0 byte, 1 half, 2 word.
- data_addr  out  ADDR_W  byte address (M_mem_pa unchanged).
- data_wstrb  out  4  byte strobes (0 for loads).
- data_wdata  out  32  replicated store data.
- data_uncached  out  1  M_mem_uncached passthrough.
- data_addr_ok  in  1  address phase accepted.
- data_data_ok  in  1  data phase complete.
- data_rdata  in  32  raw load word.
- mem_rdata  out  32  extracted, extended load result.
- mem_stall  out  1  hold pipeline.
- adel  out  1  load misaligned.
- ades  out  1  store misaligned.

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Reset values: state=IDLE; latched op/offset=0; rdata_q=0. Hence data_req=0, mem_stall=0, mem_rdata=0.
- Misalignment (combinational, gated by M_mem_en):
  - half ops with addr[0]=1, or word ops with addr[1:0]≠0.
  - Load → adel=1; store → ades=1.
- new_req = M_mem_en & (ren|wen) & supported op & !misaligned & !flush. Unsupported opcodes issue nothing and never stall.
- FSM states: IDLE, ADDR, DATA, DONE.
  - IDLE: data_req=new_req. On new_req, latch op and pa[1:0]; then addr_ok → DATA, else → ADDR.
  - ADDR: data_req=1, all bus outputs held stable. addr_ok → DATA.
  - DATA: data_req=0. On data_ok: capture processed result into rdata_q; then advance → IDLE, else → DONE.
  - DONE: data_req=0, mem_rdata=rdata_q. advance → IDLE.
- mem_stall = (IDLE & new_req) | ADDR | (DATA & !data_ok). DONE never stalls, so a request held by an unrelated stall is never reissued.
- mem_rdata:
  - In DATA with data_ok: computed combinationally from data_rdata (zero-latency forward).
  - In DONE: rdata_q.
  - Otherwise: rdata_q.
- Store encoding, by op and pa[1:0]:
  - SB: wstrb = 1<<off; wdata = {4{b}}.
  - SH: wstrb = 0011 or 1100; wdata = {2{h}}.
  - SW: wstrb = 1111.
- Load extraction:
  - byte = rdata[8*off+:8]; half = rdata[16*off[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passthrough.
- flush only gates new requests. An in-flight transaction (ADDR/DATA) completes with mem_stall asserted; its result is discarded by the flushed pipeline. Request is never withdrawn before addr_ok.
- Simultaneous addr_ok and data_ok in ADDR: data_ok ignored. The bus never returns data in the same cycle as address acceptance.
- rst mid-transaction: returns to IDLE immediately; the bus side is reset by the same rst.

Decomposition:
- Shared package (cpu_defs): opcode constants (OP_LB…OP_SW), data_size encodings, FSM state enum.
- One natural sub-module: mem_data_align. Purely combinational: wstrb/wdata/size generation and load extraction, reused by the uncached path.

Test Plan:
- LW pa=0x1000, addr_ok in cycle 0, data_ok in cycle 2 with rdata=0xDEADBEEF, advance=1 → stall for 2 cycles; mem_rdata=0xDEADBEEF at data_ok; state returns to IDLE.
- SB addr/pa offset 2, wdata=0x000000A5 → size=0, wstrb=0100, wdata=0xA5A5A5A5, wr=1.
- LB offset 3, rdata=0x80FFFFFF → mem_rdata=0xFFFFFF80. LBU on the same data → 0x00000080. LHU offset 2, rdata=0x8001_0000 → 0x00008001.
- LH addr=0x1001 → adel=1, data_req=0, stall=0. SW addr=0x1002 → ades=1.
- data_ok with advance=0 for 3 cycles → DONE; stall=0; no second data_req; mem_rdata held; advance → IDLE.
- addr_ok withheld 4 cycles with flush raised in cycle 1 → req held until addr_ok; stall until data_ok. Next request with flush=1 → no req issued.

Source files
------------

// File: rtl/cpu_defs.sv
// cpu_defs: shared opcode, access-size and MEM-stage FSM definitions
package cpu_defs;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} mau_state_t;
  function automatic logic op_supported(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
  endfunction
  function automatic logic op_misaligned(input logic [5:0] op, input logic [1:0] a);
    return (op[1:0] == 2'b01 && a[0]) || (op[1:0] == 2'b11 && a != 2'b00);
  endfunction
endpackage

// File: rtl/mem_data_align.sv
// mem_data_align: store strobe/data replication and load byte/half extraction
module mem_data_align
  import cpu_defs::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  off,
  input  logic        wr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [1:0]  size,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);
  logic is_b, is_h, sx;
  logic [7:0] b;
  logic [15:0] h;
  assign is_b = op[1:0] == 2'b00;
  assign is_h = op[1:0] == 2'b01;
  assign sx = !op[2];
  assign b = rdata[{off, 3'b000} +: 8];
  assign h = rdata[{off[1], 4'b0000} +: 16];
  // size, strobes and lane-replicated store data from op and byte offset
  always_comb begin
    size = is_b ? SIZE_B : is_h ? SIZE_H : SIZE_W;
    wstrb = !wr ? 4'b0000 : is_b ? 4'b0001 << off : is_h ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_o = is_b ? {4{wdata[7:0]}} : is_h ? {2{wdata[15:0]}} : wdata;
    rdata_o = is_b ? {{24{sx & b[7]}}, b} : is_h ? {{16{sx & h[15]}}, h} : rdata;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory initiator driving the SRAM-like cache bus
module mem_access_unit
  import cpu_defs::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              M_mem_en,
  input  logic              M_mem_ren,
  input  logic              M_mem_wen,
  input  logic [5:0]        M_mem_op,
  input  logic [31:0]       M_mem_addr,
  input  logic [31:0]       M_mem_wdata,
  input  logic [ADDR_W-1:0] M_mem_pa,
  input  logic              M_mem_uncached,
  input  logic              flush,
  input  logic              advance,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  output logic              data_uncached,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_stall,
  output logic              adel,
  output logic              ades
);
  mau_state_t state, state_n;
  logic [5:0] op_q;
  logic [ADDR_W-1:0] pa_q;
  logic [31:0] wdata_q, rdata_q, ld_data;
  logic wr_q, unc_q, idle, misal, new_req;
  assign idle = state == S_IDLE;
  assign misal = M_mem_en && op_misaligned(M_mem_op, M_mem_addr[1:0]);
  assign adel = misal && M_mem_ren;
  assign ades = misal && M_mem_wen;
  assign new_req = M_mem_en && (M_mem_ren || M_mem_wen) && op_supported(M_mem_op) && !misal && !flush;
  // bus fields come live from EX/MEM while idle, then from the latched request so they stay stable
  assign data_addr = idle ? M_mem_pa : pa_q;
  assign data_wr = idle ? M_mem_wen : wr_q;
  assign data_uncached = idle ? M_mem_uncached : unc_q;
  mem_data_align u_align (
    .op(idle ? M_mem_op : op_q),
    .off(data_addr[1:0]),
    .wr(data_wr),
    .wdata(idle ? M_mem_wdata : wdata_q),
    .rdata(data_rdata),
    .size(data_size),
    .wstrb(data_wstrb),
    .wdata_o(data_wdata),
    .rdata_o(ld_data)
  );
  // request latch, load result register and state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_q <= '0;
      pa_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
      unc_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if (idle && new_req) begin
        op_q <= M_mem_op;
        pa_q <= M_mem_pa;
        wdata_q <= M_mem_wdata;
        wr_q <= M_mem_wen;
        unc_q <= M_mem_uncached;
      end
      if (state == S_DATA && data_data_ok) rdata_q <= ld_data;
    end
  end
  // next state, request, stall and forwarded load result
  always_comb begin
    state_n = state;
    data_req = 1'b0;
    mem_stall = 1'b0;
    mem_rdata = rdata_q;
    unique case (state)
      S_IDLE: begin
        data_req = new_req;
        mem_stall = new_req;
        state_n = !new_req ? S_IDLE : data_addr_ok ? S_DATA : S_ADDR;
      end
      S_ADDR: begin
        data_req = 1'b1;
        mem_stall = 1'b1;
        state_n = data_addr_ok ? S_DATA : S_ADDR;
      end
      S_DATA: begin
        mem_stall = !data_data_ok;
        mem_rdata = data_data_ok ? ld_data : rdata_q;
        state_n = !data_data_ok ? S_DATA : advance ? S_IDLE : S_DONE;
      end
      S_DONE: state_n = advance ? S_IDLE : S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed table and sequence checks of the MEM-stage access unit
module tb_mem_access_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic en = 0, ren = 0, wen = 0, unc = 0, flush = 0, advance = 0;
  logic [5:0] op = 0;
  logic [31:0] addr = 0, wdata = 0, pa = 0, rdata = 0;
  logic addr_ok = 0, data_ok = 0;
  logic req, wr, d_unc, stall, adel, ades;
  logic [1:0] size;
  logic [3:0] wstrb;
  logic [31:0] d_addr, d_wdata, mem_rdata;
  int ncmp = 0, nerr = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .M_mem_en(en), .M_mem_ren(ren), .M_mem_wen(wen), .M_mem_op(op),
    .M_mem_addr(addr), .M_mem_wdata(wdata), .M_mem_pa(pa), .M_mem_uncached(unc),
    .flush(flush), .advance(advance), .data_req(req), .data_wr(wr), .data_size(size),
    .data_addr(d_addr), .data_wstrb(wstrb), .data_wdata(d_wdata), .data_uncached(d_unc),
    .data_addr_ok(addr_ok), .data_data_ok(data_ok), .data_rdata(rdata),
    .mem_rdata(mem_rdata), .mem_stall(stall), .adel(adel), .ades(ades)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string name;
    logic en, ren, wen;
    logic [5:0] op;
    logic [31:0] addr, wdata;
    logic bus;
    logic req, wr;
    logic [1:0] size;
    logic [3:0] wstrb;
    logic [31:0] wdo;
    logic adel, ades, stall;
  } vec_t;

  task automatic run_load(input string name, input logic [5:0] o, input logic [31:0] a,
                          input logic [31:0] rd, input logic [31:0] exp, input int waits);
    @(negedge clk);
    en = 1; ren = 1; wen = 0; op = o; addr = a; pa = a; addr_ok = 1; data_ok = 0; advance = 1;
    #1 chk({name, " req"}, req, 1);
    chk({name, " stall0"}, stall, 1);
    @(negedge clk);
    addr_ok = 0;
    for (int i = 0; i < waits; i++) begin
      #1 chk({name, " wait stall"}, stall, 1);
      chk({name, " wait req"}, req, 0);
      @(negedge clk);
    end
    data_ok = 1; rdata = rd;
    #1 chk({name, " fwd"}, mem_rdata, exp);
    chk({name, " stall off"}, stall, 0);
    @(posedge clk);
    #1 en = 0; ren = 0; data_ok = 0; rdata = 0;
    #1 chk({name, " held"}, mem_rdata, exp);
    chk({name, " idle req"}, req, 0);
  endtask

  vec_t vt[$];

  initial begin
    vt.push_back('{"sb2", 1,0,1, 6'h28, 32'h1002, 32'h000000A5, 1, 1,1, 2'd0, 4'b0100, 32'hA5A5A5A5, 0,0,1});
    vt.push_back('{"sb1", 1,0,1, 6'h28, 32'h1001, 32'h12345678, 1, 1,1, 2'd0, 4'b0010, 32'h78787878, 0,0,1});
    vt.push_back('{"sh2", 1,0,1, 6'h29, 32'h1002, 32'h1234BEEF, 1, 1,1, 2'd1, 4'b1100, 32'hBEEFBEEF, 0,0,1});
    vt.push_back('{"sh0", 1,0,1, 6'h29, 32'h1000, 32'h0000CAFE, 1, 1,1, 2'd1, 4'b0011, 32'hCAFECAFE, 0,0,1});
    vt.push_back('{"sw0", 1,0,1, 6'h2B, 32'h1000, 32'h01234567, 1, 1,1, 2'd2, 4'b1111, 32'h01234567, 0,0,1});
    vt.push_back('{"lw0", 1,1,0, 6'h23, 32'h1000, 32'h00000000, 1, 1,0, 2'd2, 4'b0000, 32'h00000000, 0,0,1});
    vt.push_back('{"lb3", 1,1,0, 6'h20, 32'h1003, 32'h00000011, 1, 1,0, 2'd0, 4'b0000, 32'h11111111, 0,0,1});
    vt.push_back('{"sw_mis", 1,0,1, 6'h2B, 32'h1002, 32'h0, 0, 0,0, 2'd0, 4'b0, 32'h0, 0,1,0});
    vt.push_back('{"lh_mis", 1,1,0, 6'h21, 32'h1001, 32'h0, 0, 0,0, 2'd0, 4'b0, 32'h0, 1,0,0});
    vt.push_back('{"lhu_mis", 1,1,0, 6'h25, 32'h1003, 32'h0, 0, 0,0, 2'd0, 4'b0, 32'h0, 1,0,0});
    vt.push_back('{"sh_mis", 1,0,1, 6'h29, 32'h1001, 32'h0, 0, 0,0, 2'd0, 4'b0, 32'h0, 0,1,0});
    vt.push_back('{"unsup", 1,1,0, 6'h22, 32'h1000, 32'h0, 0, 0,0, 2'd0, 4'b0, 32'h0, 0,0,0});
    vt.push_back('{"no_en", 0,0,1, 6'h2B, 32'h1002, 32'h0, 0, 0,0, 2'd0, 4'b0, 32'h0, 0,0,0});

    repeat (2) @(negedge clk);
    chk("rst req", req, 0);
    chk("rst stall", stall, 0);
    chk("rst rdata", mem_rdata, 0);
    rst = 0;

    foreach (vt[k]) begin
      @(negedge clk);
      en = vt[k].en; ren = vt[k].ren; wen = vt[k].wen; op = vt[k].op;
      addr = vt[k].addr; pa = vt[k].addr; wdata = vt[k].wdata; unc = vt[k].addr[0];
      #1 chk({vt[k].name, " req"}, req, vt[k].req);
      chk({vt[k].name, " adel"}, adel, vt[k].adel);
      chk({vt[k].name, " ades"}, ades, vt[k].ades);
      chk({vt[k].name, " stall"}, stall, vt[k].stall);
      if (vt[k].bus) begin
        chk({vt[k].name, " wr"}, wr, vt[k].wr);
        chk({vt[k].name, " size"}, size, vt[k].size);
        chk({vt[k].name, " wstrb"}, wstrb, vt[k].wstrb);
        chk({vt[k].name, " wdata"}, d_wdata, vt[k].wdo);
        chk({vt[k].name, " addr"}, d_addr, vt[k].addr);
        chk({vt[k].name, " unc"}, d_unc, vt[k].addr[0]);
      end
      en = 0; ren = 0; wen = 0;
    end

    run_load("lw", 6'h23, 32'h1000, 32'hDEADBEEF, 32'hDEADBEEF, 1);
    run_load("lb", 6'h20, 32'h1003, 32'h80FFFFFF, 32'hFFFFFF80, 0);
    run_load("lbu", 6'h24, 32'h1003, 32'h80FFFFFF, 32'h00000080, 0);
    run_load("lhu", 6'h25, 32'h1002, 32'h80010000, 32'h00008001, 0);
    run_load("lh", 6'h21, 32'h1002, 32'h80010000, 32'hFFFF8001, 0);
    run_load("lb0", 6'h20, 32'h1000, 32'h1234567F, 32'h0000007F, 2);

    // data_ok while pipeline is held: park in DONE, no reissue, result held
    @(negedge clk);
    en = 1; ren = 1; op = 6'h23; addr = 32'h1004; pa = 32'h1004; addr_ok = 1; advance = 0;
    @(negedge clk);
    addr_ok = 0; data_ok = 1; rdata = 32'hCAFEF00D;
    #1 chk("done fwd", mem_rdata, 32'hCAFEF00D);
    @(negedge clk);
    data_ok = 0; rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("done stall", stall, 0);
      chk("done req", req, 0);
      chk("done rdata", mem_rdata, 32'hCAFEF00D);
      @(negedge clk);
    end
    advance = 1;
    @(posedge clk);
    #1 en = 0; ren = 0;
    #1 chk("done exit req", req, 0);
    chk("done exit rdata", mem_rdata, 32'hCAFEF00D);

    // addr_ok withheld with flush raised mid-request: request stays up and stable
    @(negedge clk);
    en = 1; wen = 1; op = 6'h2B; addr = 32'h2000; pa = 32'h2000; wdata = 32'h55AA55AA; addr_ok = 0; advance = 0;
    #1 chk("fl req0", req, 1);
    chk("fl stall0", stall, 1);
    @(negedge clk);
    flush = 1; pa = 32'h3000; wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("fl req", req, 1);
      chk("fl stall", stall, 1);
      chk("fl addr", d_addr, 32'h2000);
      chk("fl wdata", d_wdata, 32'h55AA55AA);
      @(negedge clk);
    end
    addr_ok = 1;
    #1 chk("fl req ok", req, 1);
    @(negedge clk);
    addr_ok = 0;
    #1 chk("fl data req", req, 0);
    chk("fl data stall", stall, 1);
    @(negedge clk);
    data_ok = 1; advance = 1;
    #1 chk("fl data_ok stall", stall, 0);
    @(negedge clk);
    data_ok = 0;
    #1 chk("fl blocked req", req, 0);
    chk("fl blocked stall", stall, 0);
    @(negedge clk);
    en = 0; wen = 0; flush = 0;

    // reset in the middle of an address phase
    @(negedge clk);
    en = 1; ren = 1; op = 6'h23; addr = 32'h1000; pa = 32'h1000; addr_ok = 0;
    @(negedge clk);
    en = 0; ren = 0; rst = 1;
    #1 chk("rst mid req", req, 1);
    @(negedge clk);
    rst = 0;
    #1 chk("rst mid after", req, 0);
    chk("rst mid stall", stall, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
